// File: rtl/alu_out_stage.sv
// Registered ALU output stage: captures result/op, computes per-beat NZCV, keeps the architectural flag register.
// Latency 1 cycle; ALU_OUT_SKID_EN selects a 2-entry skid (registered in_ready), default is a single register.
// Backpressure: skid build stalls only when both entries are full; default build passes out_ready through to in_ready.
module alu_out_stage #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] result,
  input  logic [2:0]   op,
  input  logic         c_in,
  input  logic         v_in,
  input  logic         set_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [2:0]   out_op,
  output logic [3:0]   out_nzcv,
  output logic [3:0]   flags
);

  typedef struct packed {
    logic [N-1:0] res;
    logic [2:0]   op;
    logic [3:0]   nzcv;
    logic         sf;
  } beat_t;

`ifdef ALU_OUT_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;
`else
  typedef enum logic {S_EMPTY = 1'b0, S_ONE = 1'b1} state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  beat_t  r_out;
  beat_t  w_in_beat;
  logic [3:0] r_flags;
  logic   w_in_hs;
  logic   w_out_hs;
  logic   w_load_out;

  // Flags are fixed at capture so the output register never sits on a compare path.
  always_comb begin
    w_in_beat      = '0;
    w_in_beat.res  = result;
    w_in_beat.op   = op;
    w_in_beat.nzcv = {result[N-1], (result == '0), c_in, v_in};
    w_in_beat.sf   = set_flags;
  end

  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = out_valid && out_ready;
  assign out_result = r_out.res;
  assign out_op     = r_out.op;
  assign out_nzcv   = r_out.nzcv;
  assign flags      = r_flags;

`ifdef ALU_OUT_SKID_EN
  beat_t r_skid;
  logic  w_load_skid;
  logic  w_skid_to_out;

  // in_ready decodes only the state register, so out_ready never reaches it.
  assign in_ready = (r_state != S_TWO);

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_hs) begin
          w_state_nxt = S_ONE;
          w_load_out  = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_hs && w_out_hs) begin
          w_load_out = 1'b1;
        end else if (w_in_hs) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_out_hs) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out_hs) begin
          w_state_nxt   = S_ONE;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_in_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_load_out) begin
      r_out <= w_in_beat;
    end else if (w_skid_to_out) begin
      r_out <= r_skid;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // An accept while full implies out_ready, so the held beat leaves on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    if (w_in_hs) begin
      w_state_nxt = S_ONE;
      w_load_out  = 1'b1;
    end else if (w_out_hs) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_load_out) begin
      r_out <= w_in_beat;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Only departing beats touch the flag register, which keeps updates in program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_out_hs && r_out.sf) begin
      r_flags <= r_out.nzcv;
    end
  end

endmodule

// File: tb/tb_alu_out_stage.sv
// Scoreboard bench for alu_out_stage: accepted beats queue their expected output, departures pop and compare.
module tb_alu_out_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result;
  logic [2:0] op;
  logic       c_in;
  logic       v_in;
  logic       set_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic [3:0] out_nzcv;
  logic [3:0] flags;

  typedef struct packed {
    logic [7:0] res;
    logic [2:0] op;
    logic [3:0] nzcv;
    logic       sf;
  } exp_t;

  exp_t sb[$];
  logic [3:0] exp_flags;
  int n_checks;
  int n_errors;
  int cyc;
  int hs_cnt;
  logic       prev_stall;
  logic [7:0] prev_res;
  logic [2:0] prev_op;
  logic [3:0] prev_nzcv;

  alu_out_stage #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .op         (op),
    .c_in       (c_in),
    .v_in       (v_in),
    .set_flags  (set_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_nzcv   (out_nzcv),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: flag register, output order/value, and stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      n_checks++;
      if (flags !== exp_flags) begin
        n_errors++;
        $display("FAIL flags_reg got=%b exp=%b t=%0t", flags, exp_flags, $time);
      end
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, out_result, out_op, out_nzcv} !== {1'b1, prev_res, prev_op, prev_nzcv}) begin
          n_errors++;
          $display("FAIL stall_hold got=%b/%h/%0d/%b exp=1/%h/%0d/%b t=%0t",
                   out_valid, out_result, out_op, out_nzcv, prev_res, prev_op, prev_nzcv, $time);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat got=%h exp=none t=%0t", out_result, $time);
        end else begin
          e = sb.pop_front();
          if ({out_result, out_op, out_nzcv} !== {e.res, e.op, e.nzcv}) begin
            n_errors++;
            $display("FAIL beat got=%h/%0d/%b exp=%h/%0d/%b t=%0t",
                     out_result, out_op, out_nzcv, e.res, e.op, e.nzcv, $time);
          end
          if (e.sf) exp_flags = e.nzcv;
        end
        hs_cnt++;
      end
      if (in_valid && in_ready) begin
        e.res  = result;
        e.op   = op;
        e.nzcv = {result[7], (result == 8'h00), c_in, v_in};
        e.sf   = set_flags;
        sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_op    = out_op;
      prev_nzcv  = out_nzcv;
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] r, input logic [2:0] o, input logic c, input logic v, input logic s);
    int  n;
    logic ok;
    result = r; op = o; c_in = c; v_in = v; set_flags = s; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout got=in_ready_low exp=accept data=%h", r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    result = 8'h00; op = 3'd0; c_in = 1'b0; v_in = 1'b0; set_flags = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, out_result, out_op, out_nzcv, flags} !== {1'b0, 1'b1, 8'h00, 3'd0, 4'h0, 4'h0}) begin
      n_errors++;
      $display("FAIL reset_state got=%b/%b/%h/%0d/%b/%b exp=0/1/00/0/0000/0000",
               out_valid, in_ready, out_result, out_op, out_nzcv, flags);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flags_zero();
    out_ready = 1'b1;
    send(8'h00, 3'd3, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_nzcv} !== {1'b1, 4'b0110}) begin
      n_errors++;
      $display("FAIL zero_beat got=%b/%b exp=1/0110", out_valid, out_nzcv);
    end
    @(posedge clk); #1;
    n_checks++;
    if (flags !== 4'b0110) begin
      n_errors++;
      $display("FAIL zero_flags got=%b exp=0110", flags);
    end
  endtask

  task automatic test_flags_hold();
    send(8'h80, 3'd5, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_nzcv !== 4'b1000) begin
      n_errors++;
      $display("FAIL neg_nzcv got=%b exp=1000", out_nzcv);
    end
    @(posedge clk); #1;
    n_checks++;
    if (flags !== 4'b0110) begin
      n_errors++;
      $display("FAIL flags_hold got=%b exp=0110", flags);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    send(8'h11, 3'd1, 1'b0, 1'b0, 1'b0);
`ifdef ALU_OUT_SKID_EN
    send(8'h22, 3'd2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({in_ready, out_result} !== {1'b0, 8'h11}) begin
      n_errors++;
      $display("FAIL skid_full got=%b/%h exp=0/11", in_ready, out_result);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 8'h11}) begin
      n_errors++;
      $display("FAIL skid_hold got=%b/%b/%h exp=0/1/11", in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, out_result} !== {1'b1, 1'b1, 8'h22}) begin
      n_errors++;
      $display("FAIL skid_drain got=%b/%b/%h exp=1/1/22", in_ready, out_valid, out_result);
    end
`else
    n_checks++;
    if ({in_ready, out_result} !== {1'b0, 8'h11}) begin
      n_errors++;
      $display("FAIL reg_full got=%b/%h exp=0/11", in_ready, out_result);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 8'h11}) begin
      n_errors++;
      $display("FAIL reg_hold got=%b/%b/%h exp=0/1/11", in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    send(8'h22, 3'd2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({out_valid, out_result} !== {1'b1, 8'h22}) begin
      n_errors++;
      $display("FAIL reg_replace got=%b/%h exp=1/22", out_valid, out_result);
    end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL skid_empty got=%b/%0d exp=0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int start_cyc;
    int start_hs;
    out_ready = 1'b1;
    start_cyc = cyc;
    start_hs  = hs_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 37 + 1), 3'(i), i[0], i[1], i[2]);
    end
    n_checks++;
    if (cyc - start_cyc != 16) begin
      n_errors++;
      $display("FAIL stream_accept got=%0d exp=16 cycles", cyc - start_cyc);
    end
    @(posedge clk); #1;
    n_checks++;
    if (hs_cnt - start_hs != 16) begin
      n_errors++;
      $display("FAIL stream_emit got=%0d exp=16 beats", hs_cnt - start_hs);
    end
  endtask

  task automatic test_random();
    bit done;
    int n;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom),
               1'($urandom), 1'($urandom));
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL random_drain got=%0d/%b exp=0/0", sb.size(), out_valid);
    end
    n_checks++;
    if (flags !== exp_flags) begin
      n_errors++;
      $display("FAIL random_flags got=%b exp=%b", flags, exp_flags);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    out_ready = 1'b1;
    send(8'h80, 3'd4, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (flags !== 4'b1001) begin
      n_errors++;
      $display("FAIL pre_reset_flags got=%b exp=1001", flags);
    end
    out_ready = 1'b0;
    send(8'h33, 3'd6, 1'b0, 1'b0, 1'b1);
`ifdef ALU_OUT_SKID_EN
    send(8'h44, 3'd7, 1'b0, 1'b0, 1'b1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, flags} !== {1'b0, 1'b1, 4'h0}) begin
      n_errors++;
      $display("FAIL mid_reset got=%b/%b/%b exp=0/1/0000", out_valid, in_ready, flags);
    end
    sb.delete();
    exp_flags = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    n_checks++;
    if (bad != 0 || flags !== 4'h0) begin
      n_errors++;
      $display("FAIL post_reset got=%0d/%b exp=0/0000", bad, flags);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; hs_cnt = 0;
    exp_flags = 4'h0; prev_stall = 1'b0;
    prev_res = 8'h00; prev_op = 3'd0; prev_nzcv = 4'h0;
    test_reset();
    test_flags_zero();
    test_flags_hold();
    test_skid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
